mem_req_queue: RTL and testbench
================================

// Module: mem_req_queue
// PURPOSE
//  Downstream consumer of the trace parser: takes parsed trace records {time, core, op, addr},
//  releases each one only when simulated CPU time reaches its timestamp, and buffers it in a
//  DEPTH-entry in-order queue. The DRAM controller model drains the queue.
//  Owns the simulated CPU-cycle counter, with time-skip when the queue is idle.
// PARAMETERS
//  DEPTH      16  queue entries; power of 2, >=2
//  TIME_W     64  width of trace timestamp and sim_time
//  CORE_W     12  core id width
//  ADDR_W     36  physical address width
// PORTS
//  clk        in   1       clock
//  rst        in   1       asynchronous active-high reset
//  in_valid   in   1       parser presents a record
//  in_ready   out  1       record accepted this cycle when in_valid&&in_ready
//  in_time    in   TIME_W  trace timestamp, in CPU cycles
//  in_core    in   CORE_W  requesting core
//  in_op      in   2       0=READ 1=WRITE 2=IFETCH 3=illegal
//  in_addr    in   ADDR_W  request address
//  out_valid  out  1       head entry valid
//  out_ready  in   1       DRAM controller pops head when out_valid&&out_ready
//  out_req    out  trace_req_t  head entry {time,core,op,addr}
//  sim_time   out  TIME_W  current simulated CPU cycle
//  count      out  $clog2(DEPTH)+1  occupancy
//  full/empty out  1       count==DEPTH / count==0
//  op_err     out  1       sticky; set when an op==3 record is consumed
// BEHAVIOUR
//  Reset: sim_time=0, count=0, empty=1, full=0, out_valid=0, op_err=0, rd/wr ptrs=0; out_req=0.
//  Reset mid-operation clears all entries immediately and drops them. No pending pop completes.
//  in_ready = !full && (in_time <= sim_time). Registered-state only; no path from out_ready.
//  Enqueue: a record written at edge N is visible on out_valid/out_req after edge N (1-cycle latency).
//   No empty-bypass.
//  Illegal op: a record with in_op==3 is accepted (in_ready as above), not enqueued, and sets op_err.
//  Dequeue: head advances on out_valid&&out_ready. out_req holds stable while out_valid&&!out_ready.
//  Simultaneous push+pop: both occur; count unchanged. When full, push is blocked even if popping.
//  sim_time update per cycle, in priority order:
//   1) empty && in_valid && in_time > sim_time+1 : sim_time <= in_time (time-skip)
//   2) otherwise                                 : sim_time <= sim_time+1
//  A skip makes the record acceptable on the following cycle.
//  sim_time wraps modulo 2^TIME_W (not expected in practice).
//  Pointers: log2(DEPTH)-bit, wrap naturally at DEPTH; count tracked separately.
//  Ordering is strict FIFO. No reordering across cores.
// STRUCTURE
//  Package mem_trace_pkg: trace_op_e {OP_READ=0, OP_WRITE=1, OP_IFETCH=2};
//   trace_req_t packed struct {time, core, op, addr}; widths TIME_W/CORE_W/ADDR_W as localparams.
//  Sub-module req_fifo: generic DEPTH x trace_req_t synchronous FIFO with push/pop/count/full/empty.
//  mem_req_queue wraps req_fifo and adds the time-release gate, sim_time counter, skip and op check.
//  The trace parser bench drives the in_* port from file records instead of printing them.
// TESTING
//  1 Reset with in_valid=0 for 5 cycles -> sim_time=5, empty=1, out_valid=0, in_ready=0.
//  2 Idle, push {time=100,core=3,op=0,addr=36'h0_1234_5678} at sim_time=5
//    -> sim_time jumps to 100; accepted at 100; out_valid next cycle with identical fields.
//  3 Queue non-empty, record time=t+3 -> no skip; in_ready=0 for 3 cycles;
//    accepted when sim_time==t+3.
//  4 Push 16 records time=0, out_ready=0 -> full=1, count=16, in_ready=0.
//    Then out_ready=1 with in_valid=1 -> pops 1/cycle; refill resumes next cycle; FIFO order kept.
//  5 Record op=3 -> accepted, count unchanged, op_err=1 and stays set until rst.
//  6 Assert rst with count=7 mid-pop -> count=0, out_valid=0, sim_time=0 asynchronously;
//    no stale entry after release.

Source files
------------

// File: rtl/mem_trace_pkg.sv
// Shared widths, opcode enum and request payload for the memory trace request queue.
package mem_trace_pkg;

  localparam int unsigned TIME_W = 64;
  localparam int unsigned CORE_W = 12;
  localparam int unsigned ADDR_W = 36;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2
  } trace_op_e;

  // Head-entry payload; the timestamp field is named tstamp since 'time' is reserved.
  typedef struct packed {
    logic [TIME_W-1:0] tstamp;
    logic [CORE_W-1:0] core;
    trace_op_e         op;
    logic [ADDR_W-1:0] addr;
  } trace_req_t;

  function automatic logic is_legal_op(input logic [1:0] op);
    return op != 2'd3;
  endfunction

endpackage

// File: rtl/mem_req_queue_if.sv
// Parser-side input channel, DRAM-side output channel and status of the request queue.
interface mem_req_queue_if
  import mem_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] in_time;
  logic [CORE_W-1:0] in_core;
  logic [1:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  trace_req_t        out_req;
  logic [TIME_W-1:0] sim_time;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              op_err;

  modport slave (
    input  in_valid, in_time, in_core, in_op, in_addr, out_ready,
    output in_ready, out_valid, out_req, sim_time, count, full, empty, op_err
  );

  modport master (
    output in_valid, in_time, in_core, in_op, in_addr, out_ready,
    input  in_ready, out_valid, out_req, sim_time, count, full, empty, op_err
  );

endinterface

// File: rtl/req_fifo.sv
// In-order DEPTH x trace_req_t synchronous FIFO; reset clears storage so no stale head survives.
module req_fifo
  import mem_trace_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  trace_req_t       wdata_i,
  output trace_req_t       rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  trace_req_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mem_req_queue.sv
// Releases trace records once simulated CPU time reaches their timestamp and queues them for DRAM.
// Owns sim_time, skipping ahead to the next record's timestamp whenever the queue is idle.
module mem_req_queue
  import mem_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic            clk,
  input logic            rst,
  mem_req_queue_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [TIME_W-1:0] sim_time_q, sim_time_d, time_inc;
  logic              op_err_q, op_err_d;
  logic              ready, consume, legal, push;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  trace_req_t        wdata;

  // Acceptance depends only on registered state and the presented timestamp.
  assign ready   = !fifo_full && (bus.in_time <= sim_time_q);
  assign consume = bus.in_valid && ready;
  assign legal   = is_legal_op(bus.in_op);
  assign push    = consume && legal;

  assign wdata = '{tstamp: bus.in_time, core: bus.in_core,
                   op: trace_op_e'(bus.in_op), addr: bus.in_addr};

  req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (bus.out_ready),
    .wdata_i (wdata),
    .rdata_o (bus.out_req),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Time-skip only when idle and the next record is more than one cycle away.
  always_comb begin
    time_inc   = sim_time_q + TIME_W'(1);
    sim_time_d = time_inc;
    if (fifo_empty && bus.in_valid && (bus.in_time > time_inc)) sim_time_d = bus.in_time;
    op_err_d = op_err_q || (consume && !legal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sim_time_q <= '0;
      op_err_q   <= 1'b0;
    end else begin
      sim_time_q <= sim_time_d;
      op_err_q   <= op_err_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.sim_time  = sim_time_q;
  assign bus.count     = fifo_count;
  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.op_err    = op_err_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: reset, time-skip, release gating, full/refill, illegal op, reset drop.
module tb_mem_req_queue;
  import mem_trace_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_req_queue_if #(.DEPTH(16)) bus ();

  mem_req_queue #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [63:0] tim;
    logic [35:0] addr;
    logic        ordy;
    logic        e_rdy;
    logic        e_ovld;
    logic        e_full;
    logic [4:0]  e_cnt;
    logic [35:0] e_head;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [63:0] tim, input logic [35:0] addr,
                              input logic ordy, input logic e_rdy, input logic e_ovld,
                              input logic e_full, input logic [4:0] e_cnt,
                              input logic [35:0] e_head);
    vec_t v;
    v.vld = vld; v.tim = tim; v.addr = addr; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ovld = e_ovld; v.e_full = e_full; v.e_cnt = e_cnt; v.e_head = e_head;
    return v;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Full/refill table: 16 pushes at time 0, blocked push, then pop with refill.
    for (int i = 0; i < 16; i++)
      vecs[i] = mk(1'b1, 64'd0, 36'(i), 1'b0, 1'b1, (i > 0), 1'b0, 5'(i), 36'd0);
    vecs[16] = mk(1'b1, 64'd0, 36'd16, 1'b0, 1'b0, 1'b1, 1'b1, 5'd16, 36'd0);
    vecs[17] = mk(1'b1, 64'd0, 36'd16, 1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 36'd0);
    vecs[18] = mk(1'b1, 64'd0, 36'd16, 1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 36'd1);
    vecs[19] = mk(1'b1, 64'd0, 36'd17, 1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 36'd2);
    vecs[20] = mk(1'b0, 64'd0, 36'd0,  1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 36'd3);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_time   = 64'd100;
    bus.in_core   = '0;
    bus.in_op     = 2'd0;
    bus.in_addr   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sim_time", bus.sim_time, 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_op_err", 64'(bus.op_err), 64'd0);
    check("rst_out_req", 64'(bus.out_req.addr), 64'd0);
    rst = 1'b0;

    // 5 idle cycles after release
    repeat (5) @(negedge clk);
    check("idle_sim_time", bus.sim_time, 64'd5);
    check("idle_empty", 64'(bus.empty), 64'd1);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);

    // Time-skip to 100, accept, then visible next cycle
    bus.in_valid = 1'b1;
    bus.in_time  = 64'd100;
    bus.in_core  = 12'd3;
    bus.in_op    = 2'd0;
    bus.in_addr  = 36'h0_1234_5678;
    #1 check("skip_pre_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("skip_sim_time", bus.sim_time, 64'd100);
    check("skip_ready", 64'(bus.in_ready), 64'd1);
    check("skip_not_yet_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("acc_sim_time", bus.sim_time, 64'd101);
    check("acc_count", 64'(bus.count), 64'd1);
    check("acc_out_valid", 64'(bus.out_valid), 64'd1);
    check("acc_tstamp", bus.out_req.tstamp, 64'd100);
    check("acc_core", 64'(bus.out_req.core), 64'd3);
    check("acc_op", 64'(bus.out_req.op), 64'd0);
    check("acc_addr", 64'(bus.out_req.addr), 64'h0_1234_5678);

    // Non-empty queue: no skip, release at t+3
    bus.in_valid = 1'b1;
    bus.in_time  = 64'd104;
    bus.in_core  = 12'd5;
    bus.in_op    = 2'd1;
    bus.in_addr  = 36'hABC;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("gate_sim_time", bus.sim_time, 64'(101 + k));
      check("gate_ready_low", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    #1;
    check("gate_release_time", bus.sim_time, 64'd104);
    check("gate_ready_high", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("gate_count", 64'(bus.count), 64'd2);

    // Drain the two entries in order
    bus.out_ready = 1'b1;
    #1 check("drain0_addr", 64'(bus.out_req.addr), 64'h0_1234_5678);
    @(negedge clk);
    #1 check("drain1_addr", 64'(bus.out_req.addr), 64'hABC);
    check("drain1_op", 64'(bus.out_req.op), 64'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("drain_empty", 64'(bus.empty), 64'd1);

    // Table: fill to full, blocked push, pop with refill next cycle
    for (int i = 0; i < 21; i++) begin
      bus.in_valid  = vecs[i].vld;
      bus.in_time   = vecs[i].tim;
      bus.in_core   = 12'd0;
      bus.in_op     = 2'd0;
      bus.in_addr   = vecs[i].addr;
      bus.out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_rdy));
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_ovld));
      check($sformatf("vec%0d_full", i), 64'(bus.full), 64'(vecs[i].e_full));
      check($sformatf("vec%0d_count", i), 64'(bus.count), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d_head", i), 64'(bus.out_req.addr), 64'(vecs[i].e_head));
      @(negedge clk);
    end

    // Remaining entries come out in strict order 4..17
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 4; k < 18; k++) begin
      #1;
      check("order_valid", 64'(bus.out_valid), 64'd1);
      check($sformatf("order_head%0d", k), 64'(bus.out_req.addr), 64'(k));
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("order_empty", 64'(bus.empty), 64'd1);

    // Illegal op: consumed, not queued, sticky error
    check("op_err_before", 64'(bus.op_err), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_time  = 64'd0;
    bus.in_op    = 2'd3;
    bus.in_addr  = 36'hDEAD;
    #1 check("illegal_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op    = 2'd0;
    check("illegal_count", 64'(bus.count), 64'd0);
    check("illegal_out_valid", 64'(bus.out_valid), 64'd0);
    check("illegal_op_err", 64'(bus.op_err), 64'd1);
    repeat (3) @(negedge clk);
    check("op_err_sticky", 64'(bus.op_err), 64'd1);

    // Async reset with 7 entries while popping drops everything
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_time  = 64'd0;
      bus.in_addr  = 36'(12'h100 + i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("pre_rst_count", 64'(bus.count), 64'd7);
    bus.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_count", 64'(bus.count), 64'd0);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_sim_time", bus.sim_time, 64'd0);
    check("arst_op_err", 64'(bus.op_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_count", 64'(bus.count), 64'd0);
    check("post_rst_out_req", 64'(bus.out_req.addr), 64'd0);
    check("post_rst_sim_time", bus.sim_time, 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
